// File: rtl/rtc_bus_responder_if.sv
// Host <-> RTC responder multiplexed address/data bus.
interface rtc_bus_if;
  logic       cs_n;
  logic       ad_n;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       irq;

  modport master (
    output cs_n, ad_n, rd_n, wr_n, bus_in,
    input  bus_out, bus_oe, irq
  );

  modport slave (
    input  cs_n, ad_n, rd_n, wr_n, bus_in,
    output bus_out, bus_oe, irq
  );
endinterface

// File: rtl/rtc_bus_responder.sv
// RTC bus responder: answers host CS/AD/RD/WR strobes, keeps a BCD
// time/date register file that advances once per prescaler tick, and
// raises irq from the tick flag when enabled.
module rtc_bus_responder #(
  parameter int TICK_DIV = 100_000_000
) (
  input logic      clk,
  input logic      reset,
  rtc_bus_if.slave bus
);
  localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  // BCD increment of one field: {carry, next}; out-of-range values wrap to lo
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                         input logic [7:0] hi);
    if (v >= hi)              bcd_inc = {1'b1, lo};
    else if (v[3:0] >= 4'd9)  bcd_inc = {1'b0, v[7:4] + 4'd1, 4'h0};
    else                      bcd_inc = {1'b0, v + 8'd1};
  endfunction

  // Strobe synchronisers; index 1 is the synced value, index 2 its registered copy
  logic [1:0] cs_s, ad_s;
  logic [2:0] rd_s, wr_s;
  logic [7:0] bin_s1, bin_s2, bin_s3;

  // Register file
  logic [7:0]    addr;
  logic [1:0]    ctrl;
  logic          st_flag;
  logic [7:0]    sec, min, hour, day, mon, year;
  logic [PW-1:0] presc;
  logic          pend;

  // Output registers
  logic [7:0] out_q;
  logic       oe_q;
  logic       irq_q;

  assign bus.bus_out = out_q;
  assign bus.bus_oe  = oe_q;
  assign bus.irq     = irq_q;

  // Bring the asynchronous host strobes and data into the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_s   <= '1;
      ad_s   <= '1;
      rd_s   <= '1;
      wr_s   <= '1;
      bin_s1 <= '0;
      bin_s2 <= '0;
      bin_s3 <= '0;
    end else begin
      cs_s   <= {cs_s[0], bus.cs_n};
      ad_s   <= {ad_s[0], bus.ad_n};
      rd_s   <= {rd_s[1:0], bus.rd_n};
      wr_s   <= {wr_s[1:0], bus.wr_n};
      bin_s1 <= bus.bus_in;
      bin_s2 <= bin_s1;
      bin_s3 <= bin_s2;
    end
  end

  // Bus event decode; bin_s3 lines up with the last synced-low wr_n sample
  logic       sel, wr_rise, rd_fall, wr_ok, addr_wr, data_wr, rd_start;
  logic [7:0] wdata;
  assign sel      = ~cs_s[1];
  assign wr_rise  = wr_s[1] & ~wr_s[2];
  assign rd_fall  = ~rd_s[1] & rd_s[2];
  assign wr_ok    = wr_rise & sel & rd_s[1] & rd_s[2];  // read wins when both strobes low
  assign addr_wr  = wr_ok & ~ad_s[1];
  assign data_wr  = wr_ok & ad_s[1];
  assign rd_start = rd_fall & sel & ad_s[1];
  assign wdata    = bin_s3;

  // Tick generation; a tick colliding with a host data write waits one cycle
  logic tick, do_tick, st_clr;
  assign tick    = ctrl[0] && (presc == PRE_MAX);
  assign do_tick = (tick | pend) & ~data_wr;
  assign st_clr  = data_wr && (addr == 8'h01) && wdata[0];

  // Next values of the BCD time/date chain
  logic [8:0] sec_i, min_i, hour_i, day_i, mon_i, year_i;
  logic [7:0] dim;
  logic [1:0] ymod4;
  logic       c_min, c_hour, c_day, c_mon, c_year;
  always_comb begin
    ymod4 = {year[4], 1'b0} + year[1:0];
    case (mon)
      8'h04, 8'h06, 8'h09, 8'h11: dim = 8'h30;
      8'h02:                      dim = (ymod4 == 2'd0) ? 8'h29 : 8'h28;
      default:                    dim = 8'h31;
    endcase
    sec_i  = bcd_inc(sec,  8'h00, 8'h59);
    min_i  = bcd_inc(min,  8'h00, 8'h59);
    hour_i = bcd_inc(hour, 8'h00, 8'h23);
    day_i  = bcd_inc(day,  8'h01, dim);
    mon_i  = bcd_inc(mon,  8'h01, 8'h12);
    year_i = bcd_inc(year, 8'h00, 8'h99);
    c_min  = sec_i[8];
    c_hour = c_min  & min_i[8];
    c_day  = c_hour & hour_i[8];
    c_mon  = c_day  & day_i[8];
    c_year = c_mon  & mon_i[8];
  end

  // Read-data mux over the register map
  logic [7:0] rdata;
  always_comb begin
    rdata = '0;
    case (addr)
      8'h00: rdata = {6'b0, ctrl};
      8'h01: rdata = {7'b0, st_flag};
      8'h21: rdata = sec;
      8'h22: rdata = min;
      8'h23: rdata = hour;
      8'h24: rdata = day;
      8'h25: rdata = mon;
      8'h26: rdata = year;
      default: rdata = '0;
    endcase
  end

  // Address latch, prescaler, host writes and the per-tick BCD advance
  always_ff @(posedge clk) begin
    if (reset) begin
      addr    <= '0;
      ctrl    <= 2'b01;
      st_flag <= 1'b0;
      sec     <= 8'h00;
      min     <= 8'h00;
      hour    <= 8'h00;
      day     <= 8'h01;
      mon     <= 8'h01;
      year    <= 8'h00;
      presc   <= '0;
      pend    <= 1'b0;
    end else begin
      if (addr_wr) addr <= wdata;
      if (ctrl[0]) presc <= (presc == PRE_MAX) ? '0 : presc + PW'(1);
      st_flag <= tick | (st_flag & ~st_clr);
      if (data_wr && (tick || pend)) pend <= 1'b1;
      else if (do_tick)              pend <= 1'b0;
      if (data_wr) begin
        case (addr)
          8'h00: ctrl <= wdata[1:0];
          8'h21: sec  <= wdata;
          8'h22: min  <= wdata;
          8'h23: hour <= wdata;
          8'h24: day  <= wdata;
          8'h25: mon  <= wdata;
          8'h26: year <= wdata;
          default: ;
        endcase
      end else if (do_tick) begin
        sec <= sec_i[7:0];
        if (c_min)  min  <= min_i[7:0];
        if (c_hour) hour <= hour_i[7:0];
        if (c_day)  day  <= day_i[7:0];
        if (c_mon)  mon  <= mon_i[7:0];
        if (c_year) year <= year_i[7:0];
      end
    end
  end

  // Read snapshot and pad enable; irq follows the flag one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      oe_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (rd_start) begin
        out_q <= rdata;
        oe_q  <= 1'b1;
      end else if (oe_q && (rd_s[1] || cs_s[1])) begin
        oe_q  <= 1'b0;
      end
      irq_q <= st_flag & ctrl[1];
    end
  end
endmodule

// File: tb/tb_rtc_bus_responder.sv
// Self-checking bench for rtc_bus_responder with a fast prescaler.
module tb_rtc_bus_responder;
  localparam int TD = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  rtc_bus_if bus_if();

  rtc_bus_responder #(.TICK_DIV(TD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Cycle count since reset release; ticks land on edges where cyc is a multiple of TD
  int cyc;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [7:0] exp_q[$];
  int         last_commit;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus_if.cs_n = 1'b1; bus_if.ad_n = 1'b1; bus_if.rd_n = 1'b1; bus_if.wr_n = 1'b1;
    bus_if.bus_in = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic bus_addr(input logic [7:0] a);
    bus_if.cs_n = 1'b0; bus_if.ad_n = 1'b0; bus_if.bus_in = a; bus_if.wr_n = 1'b0;
    repeat (3) @(negedge clk);
    bus_if.wr_n = 1'b1;
    last_commit = cyc + 3;
    repeat (4) @(negedge clk);
    bus_if.cs_n = 1'b1;
  endtask

  // align < 0: commit whenever; else commit on the edge where cyc % TD == align
  task automatic bus_wdata(input logic [7:0] d, input int align);
    bus_if.cs_n = 1'b0; bus_if.ad_n = 1'b1; bus_if.bus_in = d; bus_if.wr_n = 1'b0;
    repeat (3) @(negedge clk);
    if (align >= 0)
      while (((cyc + 3) % TD) != align) @(negedge clk);
    bus_if.wr_n = 1'b1;
    last_commit = cyc + 3;
    repeat (4) @(negedge clk);
    bus_if.cs_n = 1'b1;
  endtask

  task automatic bus_rdata(input logic [7:0] e_in, input string name);
    logic [7:0] e;
    bit got, dropped;
    bus_if.ad_n = 1'b1; bus_if.cs_n = 1'b0;
    exp_q.push_back(e_in);
    bus_if.rd_n = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus_if.bus_oe === 1'b1) got = 1;
    end
    e = exp_q.pop_front();
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL %s: bus_oe never rose, expected data %h", name, e);
    end else if (bus_if.bus_out !== e) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, bus_if.bus_out, e);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus_if.bus_out !== e || bus_if.bus_oe !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_hold: got %h oe=%b expected %h oe=1", name, bus_if.bus_out, bus_if.bus_oe, e);
    end
    bus_if.rd_n = 1'b1;
    dropped = 0;
    for (int i = 0; i < 6 && !dropped; i++) begin
      @(negedge clk);
      if (bus_if.bus_oe === 1'b0) dropped = 1;
    end
    tests_run++;
    if (!dropped) begin
      tests_failed++;
      $display("FAIL %s_oe_release: bus_oe=%b expected 0", name, bus_if.bus_oe);
    end
    bus_if.cs_n = 1'b1;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    bus_addr(a);
    bus_wdata(d, -1);
  endtask

  task automatic read_reg(input logic [7:0] a, input logic [7:0] e, input string name);
    bus_addr(a);
    bus_rdata(e, name);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests_run++;
    if ({bus_if.bus_oe, bus_if.bus_out, bus_if.irq} !== 10'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: oe=%b out=%h irq=%b expected 0 00 0",
               bus_if.bus_oe, bus_if.bus_out, bus_if.irq);
    end
    bus_addr(8'h21);
    bus_rdata(to_bcd((cyc + 2) / TD), "reset_sec");
    read_reg(8'h22, 8'h00, "reset_min");
    read_reg(8'h23, 8'h00, "reset_hour");
    read_reg(8'h24, 8'h01, "reset_day");
    read_reg(8'h25, 8'h01, "reset_month");
    read_reg(8'h26, 8'h00, "reset_year");
    read_reg(8'h00, 8'h01, "reset_ctrl");
    bus_addr(8'h10);
    bus_wdata(8'hAA, -1);
    bus_rdata(8'h00, "unmapped");
  endtask

  task automatic test_rollover(input string name, input logic [7:0] y, input logic [7:0] m,
                               input logic [7:0] d, input logic [7:0] ed, input logic [7:0] em);
    int w, c, n;
    do_reset();
    write_reg(8'h26, y);
    write_reg(8'h25, m);
    write_reg(8'h24, d);
    write_reg(8'h23, 8'h23);
    write_reg(8'h22, 8'h59);
    bus_addr(8'h21);
    bus_wdata(8'h59, 1);
    w = last_commit;
    while (cyc < w + 10) @(negedge clk);
    write_reg(8'h00, 8'h00);
    c = last_commit;
    n = c / TD - w / TD;
    read_reg(8'h21, to_bcd(n - 1), {name, "_sec"});
    read_reg(8'h22, 8'h00, {name, "_min"});
    read_reg(8'h23, 8'h00, {name, "_hour"});
    read_reg(8'h24, ed,    {name, "_day"});
    read_reg(8'h25, em,    {name, "_month"});
    read_reg(8'h26, y,     {name, "_year"});
  endtask

  task automatic test_irq();
    int w, c;
    bit got, bad;
    do_reset();
    write_reg(8'h00, 8'h03);
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (bus_if.irq === 1'b1) got = 1;
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL irq_set: irq=%b expected 1", bus_if.irq);
    end
    bus_addr(8'h01);
    bus_wdata(8'h01, 1);
    w = last_commit;
    while (cyc < w + 2) @(negedge clk);
    tests_run++;
    if (bus_if.irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_clear: irq=%b expected 0", bus_if.irq);
    end
    while (cyc < w + 9) @(negedge clk);
    tests_run++;
    if (bus_if.irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_latency_lo: irq=%b expected 0", bus_if.irq);
    end
    @(negedge clk);
    tests_run++;
    if (bus_if.irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_latency_hi: irq=%b expected 1", bus_if.irq);
    end
    write_reg(8'h00, 8'h01);
    c = last_commit;
    while (cyc < c + 1) @(negedge clk);
    bad = 0;
    repeat (30) begin
      if (bus_if.irq !== 1'b0) bad = 1;
      @(negedge clk);
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL irq_disabled: irq seen high, expected 0 throughout");
    end
    read_reg(8'h01, 8'h01, "status_sticky");
  endtask

  task automatic test_status_race();
    do_reset();
    bus_addr(8'h01);
    bus_wdata(8'h01, 1);
    bus_rdata(8'h00, "status_cleared");
    bus_wdata(8'h01, 0);
    bus_rdata(8'h01, "status_set_wins");
  endtask

  task automatic test_pending();
    do_reset();
    bus_addr(8'h21);
    bus_wdata(8'h30, 0);
    bus_rdata(8'h31, "pending_tick");
  endtask

  task automatic test_rd_wr_overlap();
    logic [7:0] e;
    bit got;
    do_reset();
    bus_addr(8'h26);
    bus_if.cs_n = 1'b0; bus_if.ad_n = 1'b1; bus_if.bus_in = 8'h55;
    exp_q.push_back(8'h00);
    bus_if.wr_n = 1'b0; bus_if.rd_n = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus_if.bus_oe === 1'b1) got = 1;
    end
    e = exp_q.pop_front();
    tests_run++;
    if (!got || bus_if.bus_out !== e) begin
      tests_failed++;
      $display("FAIL overlap_read: got %h oe=%b expected %h oe=1", bus_if.bus_out, bus_if.bus_oe, e);
    end
    bus_if.wr_n = 1'b1;
    repeat (4) @(negedge clk);
    bus_if.rd_n = 1'b1;
    repeat (4) @(negedge clk);
    bus_if.cs_n = 1'b1;
    read_reg(8'h26, 8'h00, "overlap_write_ignored");
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] e;
    bit got;
    do_reset();
    write_reg(8'h26, 8'h77);
    bus_addr(8'h24);
    bus_if.cs_n = 1'b0; bus_if.ad_n = 1'b1;
    exp_q.push_back(8'h01);
    bus_if.rd_n = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus_if.bus_oe === 1'b1) got = 1;
    end
    e = exp_q.pop_front();
    tests_run++;
    if (!got || bus_if.bus_out !== e) begin
      tests_failed++;
      $display("FAIL midread_data: got %h oe=%b expected %h oe=1", bus_if.bus_out, bus_if.bus_oe, e);
    end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus_if.bus_oe !== 1'b0 || bus_if.bus_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL midread_abort: oe=%b out=%h expected 0 00", bus_if.bus_oe, bus_if.bus_out);
    end
    bus_if.rd_n = 1'b1; bus_if.cs_n = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    read_reg(8'h26, 8'h00, "midread_year");
    read_reg(8'h24, 8'h01, "midread_day");
    read_reg(8'h00, 8'h01, "midread_ctrl");
  endtask

  initial begin
    bus_if.cs_n = 1'b1; bus_if.ad_n = 1'b1; bus_if.rd_n = 1'b1; bus_if.wr_n = 1'b1;
    bus_if.bus_in = 8'h00;
    test_reset();
    test_rollover("day_roll",  8'h00, 8'h01, 8'h01, 8'h02, 8'h01);
    test_rollover("leap_feb",  8'h24, 8'h02, 8'h28, 8'h29, 8'h02);
    test_rollover("plain_feb", 8'h23, 8'h02, 8'h28, 8'h01, 8'h03);
    test_irq();
    test_status_race();
    test_pending();
    test_rd_wr_overlap();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, expected completion");
    $fatal(1);
  end
endmodule
